// File: rtl/vsn_adc_capture.sv
// vsn_adc_capture
// Captures qualified ADC samples from the cable side into a small FIFO and
// streams them out as an AXI4-Stream manager. A three-state controller
// (IDLE / RUN / DRAIN) gates capture, and samples that find the FIFO full
// are dropped and counted in a saturating 16-bit overflow counter.
//
// Optional feature: define VSN_CAPTURE_TLAST_EN to store a tlast bit with
// every accepted sample, set on every FRAME_LEN-th accepted write. Without
// the macro, m_tlast is tied to 0 and no frame counter or tlast storage is
// built.
//
// Buffer organisation: the sample array is written at the write pointer and
// read through a registered port addressed by the *next* read pointer. A
// write-through bypass covers the case where the slot being written is the
// one that becomes the head. The result is one-cycle write-to-output latency
// on an empty FIFO and a head word that stays stable while the sink stalls.
module vsn_adc_capture #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic [15:0]           overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // Reject unusable configurations at elaboration time.
  generate
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vsn_adc_capture: FIFO_DEPTH must be a power of 2 and at least 4");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame
      $error("vsn_adc_capture: FRAME_LEN must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Pointers carry one extra wrap bit so that full and empty are distinct.
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_reg;

  logic [15:0] overflow_reg;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;
  logic run_entry;
  logic head_bypass;

  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full   = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  assign m_tvalid    = ~fifo_empty;
  assign pop         = m_tvalid & m_tready;

  // Samples are only offered while RUN is the registered state, so the
  // cycle that carries the IDLE->RUN edge never writes.
  assign push_req    = (state_reg == RUN) & sample_valid;
  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign push        = push_req & (~fifo_full | pop);
  assign drop        = push_req & ~push;
  assign run_entry   = (state_reg == IDLE) & enable;

  assign wr_ptr_next = wr_ptr_reg + PW'(push);
  assign rd_ptr_next = rd_ptr_reg + PW'(pop);

  // The incoming sample becomes the head when the slot it lands in is the
  // slot the read side will point at after this edge.
  assign head_bypass = push & (wr_ptr_reg == rd_ptr_next);

  assign m_tdata        = data_reg;
  assign busy           = (state_reg != IDLE);
  assign overflow_count = overflow_reg;

  // Controller state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a re-request during DRAIN takes priority over going idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_next = RUN;
        end else if (fifo_empty) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FIFO pointers; reset empties the buffer so no stale beats survive.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Sample storage write port.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= sample_in;
    end
  end

  // Registered read of the head word, with write-through for a new head.
  always_ff @(posedge aclk) begin
    if (head_bypass) begin
      data_reg <= sample_in;
    end else begin
      data_reg <= mem[rd_ptr_next[AW-1:0]];
    end
  end

  // Dropped-sample counter: cleared on each fresh capture, saturates at max.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_reg <= '0;
    end else if (run_entry) begin
      overflow_reg <= '0;
    end else if (drop && (overflow_reg != 16'hFFFF)) begin
      overflow_reg <= overflow_reg + 16'd1;
    end
  end

`ifdef VSN_CAPTURE_TLAST_EN
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [FW-1:0] frame_cnt_reg;
  logic          last_mem [FIFO_DEPTH];
  logic          last_reg;
  logic          last_in;

  // The FRAME_LEN-th accepted write of a frame carries the end marker.
  assign last_in = (frame_cnt_reg == FW'(FRAME_LEN - 1));

  // Frame position, advanced only by accepted writes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt_reg <= '0;
    end else if (run_entry) begin
      frame_cnt_reg <= '0;
    end else if (push) begin
      if (last_in) begin
        frame_cnt_reg <= '0;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + FW'(1);
      end
    end
  end

  // tlast storage alongside each sample.
  always_ff @(posedge aclk) begin
    if (push) begin
      last_mem[wr_ptr_reg[AW-1:0]] <= last_in;
    end
  end

  // Registered read of the head tlast bit, same bypass as the data.
  always_ff @(posedge aclk) begin
    if (head_bypass) begin
      last_reg <= last_in;
    end else begin
      last_reg <= last_mem[rd_ptr_next[AW-1:0]];
    end
  end

  // Qualify with valid so tlast is low whenever nothing is presented.
  assign m_tlast = last_reg & m_tvalid;
`else
  assign m_tlast = 1'b0;
`endif

endmodule

// File: doc/vsn_adc_capture.md
VSN_ADC_CAPTURE -- requirements
Module: vsn_adc_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, giving the sample and tdata width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the buffer depth; it SHALL be a power of 2 and at least 4.
REQ-003 SHALL have parameter FRAME_LEN, default 256, giving the number of beats per tlast frame; it SHALL be at least 1.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable, input, 1 bit: capture request, level-sensitive.
REQ-007 SHALL have port sample_in, input, DATA_WIDTH bits: the cable-side ADC sample (vsn_port b side).
REQ-008 SHALL have port sample_valid, input, 1 bit: qualifies sample_in for one cycle.
REQ-009 SHALL have port m_tdata, output, DATA_WIDTH bits: the AXI4-Stream manager data.
REQ-010 SHALL have port m_tvalid, output, 1 bit: the AXI4-Stream valid.
REQ-011 SHALL have port m_tready, input, 1 bit: the AXI4-Stream ready.
REQ-012 SHALL have port m_tlast, output, 1 bit: end-of-frame marker.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port overflow_count, output, 16 bits: count of dropped samples, saturating.

Function
REQ-015 SHALL implement a state machine with states IDLE, RUN and DRAIN.
REQ-016 SHALL move IDLE->RUN on enable=1, RUN->DRAIN on enable=0, DRAIN->IDLE when the FIFO is empty, and DRAIN->RUN on enable=1.
REQ-017 SHALL write samples into the FIFO only in RUN, only when sample_valid=1, and only on cycles after the RUN-entry edge.
REQ-018 SHALL accept a write when the FIFO is not full, or when it is full and a pop (m_tvalid & m_tready) occurs in the same cycle.
REQ-019 SHALL drop a sample and increment overflow_count when the sample is offered in RUN and the write is not accepted; overflow_count SHALL saturate at 0xFFFF.
REQ-020 SHALL drive m_tvalid=1 if and only if the FIFO is non-empty.
REQ-021 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-022 SHALL present a sample written at edge N on m_tdata with m_tvalid=1 after edge N (one-cycle latency when the FIFO was empty).
REQ-023 SHALL deliver samples in write order, and SHALL allow simultaneous push and pop, with the occupancy unchanged in that case.
REQ-024 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and distinguish full from empty with an extra pointer bit.
REQ-025 SHALL discard sample_valid in IDLE and DRAIN without counting an overflow.
REQ-026 SHALL output data continuously in DRAIN until the FIFO is empty.
REQ-027 SHALL clear overflow_count on each IDLE->RUN transition and hold it otherwise, except for increments.

Reset
REQ-028 SHALL, on aresetn=0, asynchronously force: state IDLE, FIFO empty, m_tvalid=0, m_tlast=0, busy=0, overflow_count=0, frame counter=0.
REQ-029 SHALL, on reset assertion mid-frame or mid-drain, discard all buffered samples and not emit a partial frame after release.
REQ-030 SHALL treat m_tdata as don't-care while m_tvalid=0, including during reset.

Configuration
REQ-031 SHALL, when macro VSN_CAPTURE_TLAST_EN is defined, store a tlast bit with each accepted sample, set on every FRAME_LEN-th accepted write.
REQ-032 SHALL, with VSN_CAPTURE_TLAST_EN defined, count only accepted writes in the frame counter (dropped samples do not advance it) and reset the counter to 0 on IDLE->RUN.
REQ-033 SHALL, without VSN_CAPTURE_TLAST_EN, tie m_tlast to constant 0 and omit the frame counter and the FIFO tlast storage.

Verification
REQ-034 SHALL cover basic capture: enable=1, m_tready=1, samples 0x1..0x5 on consecutive cycles -> m_tdata 0x1..0x5 in order, each one cycle after its write, overflow_count=0.
REQ-035 SHALL cover overflow: FIFO_DEPTH=16, m_tready=0, 20 valid samples in RUN -> m_tvalid=1, 16 samples held, overflow_count=4; then m_tready=1 -> first 16 samples out in order.
REQ-036 SHALL cover the full-FIFO push+pop: FIFO full, m_tready=1 and sample_valid=1 in the same cycle -> sample accepted, occupancy stays 16, overflow_count unchanged.
REQ-037 SHALL cover framing (macro defined): FRAME_LEN=4, 9 accepted samples -> m_tlast=1 on beats 4 and 8 only; with macro undefined -> m_tlast always 0.
REQ-038 SHALL cover drain: 6 samples buffered with m_tready=0, then enable=0 -> state DRAIN, busy=1, later samples ignored; m_tready=1 -> 6 beats out, then IDLE, busy=0.
REQ-039 SHALL cover reset mid-operation: aresetn=0 with 8 samples buffered -> m_tvalid=0 and overflow_count=0 immediately, without waiting for a clock edge; after release with enable=0 -> no output beats.
